// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_e        : sequencer states (idle, memory issue, read-data capture)
//   PORT_A, PORT_B : requester indices; also the encoding of last_grant
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
//   a_* / b_*  : request (req, we, addr, wdata) and response (gnt, rvalid, wack, rdata)
//   mem_*      : dataMemory address/write_data/memwrite/memread and read_data
//   err        : rejected-request pulse
// Modports: slave = arbiter view; master = environment view (requesters plus memory).
interface dmem_arbiter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             a_req;
  logic             a_we;
  logic [WIDTH-1:0] a_addr;
  logic [WIDTH-1:0] a_wdata;
  logic             a_gnt;
  logic             a_rvalid;
  logic             a_wack;
  logic [WIDTH-1:0] a_rdata;

  logic             b_req;
  logic             b_we;
  logic [WIDTH-1:0] b_addr;
  logic [WIDTH-1:0] b_wdata;
  logic             b_gnt;
  logic             b_rvalid;
  logic             b_wack;
  logic [WIDTH-1:0] b_rdata;

  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_write_data;
  logic             mem_memwrite;
  logic             mem_memread;
  logic [WIDTH-1:0] mem_read_data;

  logic             err;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_read_data,
    output a_gnt, a_rvalid, a_wack, a_rdata,
    output b_gnt, b_rvalid, b_wack, b_rdata,
    output mem_address, mem_write_data, mem_memwrite, mem_memread,
    output err
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_read_data,
    input  a_gnt, a_rvalid, a_wack, a_rdata,
    input  b_gnt, b_rvalid, b_wack, b_rdata,
    input  mem_address, mem_write_data, mem_memwrite, mem_memread,
    input  err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant.
//   req[1:0]   : request from PORT_B (bit 1) and PORT_A (bit 0)
//   last_grant : port granted most recently; loses a tie
//   valid      : at least one request present
//   grant      : winning port index (meaningful only when valid)
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |req;
    grant = PORT_A;
    case (req)
      2'b01:   grant = PORT_A;
      2'b10:   grant = PORT_B;
      2'b11:   grant = ~last_grant;
      default: grant = PORT_A;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the single-port data memory.
// Serialises port A / port B requests onto dataMemory and absorbs its one-cycle
// registered read latency. All outputs are registered.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave (requester ports, memory ports, err)
// Build option ADDR_CHECK_EN: when defined, a winner with addr >= DEPTH gets gnt and
// err together and no memory access; otherwise err is held at 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256
) (
  input logic            clk,
  input logic            rst_n,
  dmem_arbiter_if.slave  bus
);

  if (DEPTH == 0) begin : g_bad_depth
    $error("DEPTH must be nonzero");
  end

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             port_q, port_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic             a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic             a_wack_q, a_wack_d, b_wack_q, b_wack_d;
  logic [WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic             memwrite_q, memwrite_d, memread_q, memread_d;
  logic             err_q, err_d;

  logic             arb_valid, arb_grant;
  logic             win_we;
  logic [WIDTH-1:0] win_addr, win_wdata;
  logic             reject;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.b_req, bus.a_req}),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  assign win_we    = (arb_grant == PORT_B) ? bus.b_we    : bus.a_we;
  assign win_addr  = (arb_grant == PORT_B) ? bus.b_addr  : bus.a_addr;
  assign win_wdata = (arb_grant == PORT_B) ? bus.b_wdata : bus.a_wdata;

`ifdef ADDR_CHECK_EN
  assign reject = (win_addr >= WIDTH'(DEPTH));
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
    a_wack_d     = 1'b0;
    b_wack_d     = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    memwrite_d   = 1'b0;
    memread_d    = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          last_grant_d = arb_grant;
          port_d       = arb_grant;
          we_d         = win_we;
          addr_d       = win_addr;
          wdata_d      = win_wdata;
          a_gnt_d      = (arb_grant == PORT_A);
          b_gnt_d      = (arb_grant == PORT_B);
          if (reject) begin
            // Accepted and dropped: stay idle, no memory strobe.
            err_d = 1'b1;
          end else begin
            // Strobes are registered here so they are live during StIssue.
            state_d    = StIssue;
            memwrite_d = win_we;
            memread_d  = ~win_we;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d  = StIdle;
          a_wack_d = (port_q == PORT_A);
          b_wack_d = (port_q == PORT_B);
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        state_d = StIdle;
        if (port_q == PORT_A) begin
          a_rdata_d  = bus.mem_read_data;
          a_rvalid_d = 1'b1;
        end else begin
          b_rdata_d  = bus.mem_read_data;
          b_rvalid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= PORT_B;  // port A wins the first tie
      port_q       <= PORT_A;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_wack_q     <= 1'b0;
      b_wack_q     <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      memwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_wack_q     <= a_wack_d;
      b_wack_q     <= b_wack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      memwrite_q   <= memwrite_d;
      memread_q    <= memread_d;
      err_q        <= err_d;
    end
  end

  assign bus.a_gnt          = a_gnt_q;
  assign bus.b_gnt          = b_gnt_q;
  assign bus.a_rvalid       = a_rvalid_q;
  assign bus.b_rvalid       = b_rvalid_q;
  assign bus.a_wack         = a_wack_q;
  assign bus.b_wack         = b_wack_q;
  assign bus.a_rdata        = a_rdata_q;
  assign bus.b_rdata        = b_rdata_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_memwrite   = memwrite_q;
  assign bus.mem_memread    = memread_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed requests, a latency-rule reference model compared
// on every negative clock edge, and hand-computed literal expectations.
module tb_dmem_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 256;
`ifdef ADDR_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.WIDTH(WIDTH)) bus ();

  dmem_arbiter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in dataMemory: mem[i] = i until written, one-cycle registered read.
  logic [31:0] bmem_v [256];
  bit          bmem_w [256];
  always @(posedge clk) begin
    if (bus.mem_memwrite) begin
      bmem_v[bus.mem_address[7:0]] <= bus.mem_write_data;
      bmem_w[bus.mem_address[7:0]] <= 1'b1;
    end
    if (bus.mem_memread)
      bus.mem_read_data <= bmem_w[bus.mem_address[7:0]] ? bmem_v[bus.mem_address[7:0]]
                                                          : 32'(bus.mem_address[7:0]);
  end

  // Expected outputs per cycle, indexed by rising-edge count modulo 8.
  typedef struct {
    bit          a_gnt, a_rvalid, a_wack;
    bit          b_gnt, b_rvalid, b_wack;
    bit          rd, wr, err;
    logic [31:0] a_rdata, b_rdata, addr, wdata;
  } exp_t;

  exp_t        sl [8];
  int          cyc = 0;
  int          free_at = 0;
  bit          last_b = 1'b1;
  logic [31:0] ref_v [256];
  bit          ref_w [256];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a request seen at rising edge n produces gnt and the memory
  // strobe after edge n, wack after edge n+1 or rvalid after edge n+2, and the
  // arbiter next samples at edge n+2 (write) or n+3 (read).
  task automatic run_model();
    bit          w, we;
    logic [31:0] addr, wdata, val;
    int          s;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) sl[i] = '{default: '0};
        free_at = 0;
        last_b  = 1'b1;
      end else begin
        cyc++;
        sl[(cyc + 2) % 8] = '{default: '0};
        if (cyc >= free_at && (bus.a_req || bus.b_req)) begin
          if (bus.a_req && bus.b_req) w = ~last_b;
          else                        w = bus.b_req;
          we    = w ? bus.b_we    : bus.a_we;
          addr  = w ? bus.b_addr  : bus.a_addr;
          wdata = w ? bus.b_wdata : bus.a_wdata;
          s = cyc % 8;
          if (w) sl[s].b_gnt = 1'b1;
          else   sl[s].a_gnt = 1'b1;
          last_b = w;
          if (ChkEn && addr >= DEPTH) begin
            sl[s].err = 1'b1;
            free_at   = cyc + 1;
          end else if (we) begin
            sl[s].wr    = 1'b1;
            sl[s].addr  = addr;
            sl[s].wdata = wdata;
            ref_v[addr % 256] = wdata;
            ref_w[addr % 256] = 1'b1;
            if (w) sl[(cyc + 1) % 8].b_wack = 1'b1;
            else   sl[(cyc + 1) % 8].a_wack = 1'b1;
            free_at = cyc + 2;
          end else begin
            sl[s].rd   = 1'b1;
            sl[s].addr = addr;
            val = ref_w[addr % 256] ? ref_v[addr % 256] : (addr % 256);
            if (w) begin
              sl[(cyc + 2) % 8].b_rvalid = 1'b1;
              sl[(cyc + 2) % 8].b_rdata  = val;
            end else begin
              sl[(cyc + 2) % 8].a_rvalid = 1'b1;
              sl[(cyc + 2) % 8].a_rdata  = val;
            end
            free_at = cyc + 3;
          end
        end
      end
    end
  endtask

  task automatic run_compare();
    exp_t        e;
    logic [31:0] sa = '0;
    logic [31:0] sb = '0;
    forever begin
      @(negedge clk);
      e = sl[cyc % 8];
      if (!rst_n) begin
        sa = '0;
        sb = '0;
      end else begin
        if (e.a_rvalid) sa = e.a_rdata;
        if (e.b_rvalid) sb = e.b_rdata;
      end
      chk("m_a_gnt",    32'(bus.a_gnt),        32'(e.a_gnt));
      chk("m_b_gnt",    32'(bus.b_gnt),        32'(e.b_gnt));
      chk("m_a_rvalid", 32'(bus.a_rvalid),     32'(e.a_rvalid));
      chk("m_b_rvalid", 32'(bus.b_rvalid),     32'(e.b_rvalid));
      chk("m_a_wack",   32'(bus.a_wack),       32'(e.a_wack));
      chk("m_b_wack",   32'(bus.b_wack),       32'(e.b_wack));
      chk("m_memread",  32'(bus.mem_memread),  32'(e.rd));
      chk("m_memwrite", 32'(bus.mem_memwrite), 32'(e.wr));
      chk("m_err",      32'(bus.err),          32'(e.err));
      chk("m_a_rdata",  bus.a_rdata,           sa);
      chk("m_b_rdata",  bus.b_rdata,           sb);
      if (e.rd || e.wr) chk("m_mem_address", bus.mem_address, e.addr);
      if (e.wr)         chk("m_mem_wdata",   bus.mem_write_data, e.wdata);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
  endtask

  // Called just after a rising edge. gk/rk: edges from request until gnt / response.
  task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int gk, output int rk,
                       output logic [31:0] rdata, output bit saw_op);
    int k = 0;
    gk = 0; rk = 0; rdata = '0; saw_op = 1'b0;
    drive(port, 1'b1, we, addr, wdata);
    while (rk == 0 && k < 12) begin
      @(posedge clk);
      k++;
      if (gk != 0 && k == gk + 1) begin
        #1;
        drive(port, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
      if (gk == 0 && (port ? bus.b_gnt : bus.a_gnt)) begin
        gk     = k;
        saw_op = (we ? bus.mem_memwrite : bus.mem_memread) && (bus.mem_address == addr);
      end
      if (gk != 0 && (we ? (port ? bus.b_wack : bus.a_wack)
                         : (port ? bus.b_rvalid : bus.a_rvalid))) begin
        rk    = k;
        rdata = port ? bus.b_rdata : bus.a_rdata;
      end
    end
    drive(port, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          gk, rk, na, nb, ng, nrv, nrd;
    logic [31:0] rd;
    bit          op, dropped;
    logic [3:0]  gbits;

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    fork
      run_model();
      run_compare();
      begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'({bus.a_gnt, bus.a_rvalid, bus.a_wack, bus.b_gnt, bus.b_rvalid,
                         bus.b_wack, bus.mem_memwrite, bus.mem_memread, bus.err}), 32'd0);
    chk("rst_a_rdata", bus.a_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_address, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Port A read of address 5.
    issue(1'b0, 1'b0, 32'd5, '0, gk, rk, rd, op);
    chk("a_rd_gnt_lat", 32'(gk), 32'd1);
    chk("a_rd_memread", 32'(op), 32'd1);
    chk("a_rd_rvalid_lat", 32'(rk), 32'd3);
    chk("a_rd_data", rd, 32'd5);
    chk("a_rd_b_rdata_quiet", bus.b_rdata, 32'd0);

    // Port B write then read back.
    issue(1'b1, 1'b1, 32'd10, 32'hDEADBEEF, gk, rk, rd, op);
    chk("b_wr_gnt_lat", 32'(gk), 32'd1);
    chk("b_wr_memwrite", 32'(op), 32'd1);
    chk("b_wr_wack_lat", 32'(rk), 32'd2);
    issue(1'b1, 1'b0, 32'd10, '0, gk, rk, rd, op);
    chk("b_rd_rvalid_lat", 32'(rk), 32'd3);
    chk("b_rd_data", rd, 32'hDEADBEEF);

    // Both ports requesting continuously: grants must alternate starting with A.
    drive(1'b0, 1'b1, 1'b0, 32'd1, '0);
    drive(1'b1, 1'b1, 1'b0, 32'd2, '0);
    ng = 0; na = 0; nb = 0; gbits = '0; dropped = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      if (ng == 4 && !dropped) begin
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        dropped = 1'b1;
      end
      @(negedge clk);
      if (bus.a_gnt && ng < 4) begin gbits[ng] = 1'b0; ng++; end
      if (bus.b_gnt && ng < 4) begin gbits[ng] = 1'b1; ng++; end
      if (bus.a_rvalid) begin na++; chk("alt_a_rdata", bus.a_rdata, 32'd1); end
      if (bus.b_rvalid) begin nb++; chk("alt_b_rdata", bus.b_rdata, 32'd2); end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("alt_grant_count", 32'(ng), 32'd4);
    chk("alt_order", 32'(gbits), 32'b1010);
    chk("alt_a_rvalids", 32'(na), 32'd2);
    chk("alt_b_rvalids", 32'(nb), 32'd2);
    @(posedge clk);
    #1;

    // Reset during CAPTURE of a port A read: no rvalid, outputs cleared at once.
    drive(1'b0, 1'b1, 1'b0, 32'd7, '0);
    @(posedge clk);
    @(negedge clk);
    chk("rstcap_gnt", 32'(bus.a_gnt), 32'd1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstcap_ctrl", 32'({bus.a_gnt, bus.a_rvalid, bus.a_wack, bus.b_gnt, bus.b_rvalid,
                            bus.b_wack, bus.mem_memwrite, bus.mem_memread, bus.err}), 32'd0);
    chk("rstcap_a_rdata", bus.a_rdata, 32'd0);
    chk("rstcap_b_rdata", bus.b_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nrv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.a_rvalid) nrv++;
    end
    chk("rstcap_no_rvalid", 32'(nrv), 32'd0);
    @(posedge clk);
    #1;

    // Tie right after reset goes to A; B is not queued.
    drive(1'b0, 1'b1, 1'b0, 32'd3, '0);
    drive(1'b1, 1'b1, 1'b0, 32'd4, '0);
    @(posedge clk);
    @(negedge clk);
    chk("tie_a_gnt", 32'(bus.a_gnt), 32'd1);
    chk("tie_b_gnt", 32'(bus.b_gnt), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("tie_a_rdata", bus.a_rdata, 32'd3);
    chk("tie_b_rdata", bus.b_rdata, 32'd0);

    // Out-of-range address 300.
`ifdef ADDR_CHECK_EN
    drive(1'b0, 1'b1, 1'b0, 32'd300, '0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("oor_gnt", 32'(bus.a_gnt), 32'd1);
    chk("oor_err", 32'(bus.err), 32'd1);
    nrd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_memread) nrd++;
    end
    chk("oor_no_memread", 32'(nrd), 32'd0);
    @(posedge clk);
    #1;
`else
    nrd = 0;
    issue(1'b0, 1'b0, 32'd300, '0, gk, rk, rd, op);
    chk("oor_pass_gnt_lat", 32'(gk), 32'd1);
    chk("oor_pass_memread", 32'(op), 32'd1);
    chk("oor_pass_rdata", rd, 32'd44);
    chk("oor_pass_err", 32'(bus.err), 32'd0);
`endif

    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the single-port data memory (dataMemory). It accepts read/write requests from port A (CPU load/store unit) and port B (DMA/debug loader), serialises them onto the memory's address/write_data/memwrite/memread interface, and returns read data with a valid pulse to the winning requester. It sits between the two masters and dataMemory; the memory's one-cycle registered read latency is absorbed here.

Parameters:
WIDTH, 32, data and address width; matches dataMemory Width.
DEPTH, 256, number of memory words; used only by the optional address check.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
a_req  input  1  port A request; held stable with a_we/a_addr/a_wdata until a_gnt
a_we  input  1  port A: 1 = write, 0 = read
a_addr  input  WIDTH  port A word address
a_wdata  input  WIDTH  port A write data
a_gnt  output  1  one-cycle pulse: port A request accepted
a_rvalid  output  1  one-cycle pulse: a_rdata valid (reads only)
a_wack  output  1  one-cycle pulse: port A write completed
a_rdata  output  WIDTH  port A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_wack, b_rdata  same as port A, for port B
mem_address  output  WIDTH  to dataMemory address
mem_write_data  output  WIDTH  to dataMemory write_data
mem_memwrite  output  1  to dataMemory memwrite
mem_memread  output  1  to dataMemory memread
mem_read_data  input  WIDTH  from dataMemory read_data
err  output  1  one-cycle pulse on rejected request (ADDR_CHECK_EN only; tied 0 otherwise)

Behaviour:
- All outputs registered. Reset (rst_n low, asynchronous): state IDLE; every output 0; last_grant = B so port A wins first tie.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: sample a_req/b_req. None -> stay. One -> that port wins. Both -> port not equal to last_grant wins. Winner's we/addr/wdata latched; gnt pulsed next cycle; last_grant updated; -> ISSUE.
- ISSUE (1 cycle): mem_address/mem_write_data = latched values; exactly one of mem_memwrite/mem_memread = 1. Write -> IDLE, wack pulsed in the following cycle. Read -> CAPTURE.
- CAPTURE (1 cycle): mem_read_data valid; registered into winner's rdata, rvalid pulsed next cycle; -> IDLE.
- Latency from req sampled at edge E: gnt in cycle E+1; write wack in E+2; read rvalid in E+3. Throughput: one write per 2 cycles, one read per 3 cycles.
- mem_memwrite/mem_memread are 0 in IDLE and CAPTURE; never both 1.
- Requester drops req on the edge after seeing gnt; a req still high when FSM returns to IDLE is a new request.
- Non-winning req is ignored (not queued) and re-arbitrated at the next IDLE. With both held high continuously, grants strictly alternate.
- rdata holds its last value until the next read for that port.
- rst_n asserted mid-transaction: access abandoned, no rvalid/wack issued; memory write already issued in ISSUE is not undone.

Optional Feature:
ADDR_CHECK_EN: defined -> in IDLE, winner with addr >= DEPTH gets gnt and err pulsed together, no memory access, FSM stays IDLE, last_grant still updated. Undefined -> no check; err tied 0; out-of-range addresses are passed through.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, ISSUE, CAPTURE), port index constants PORT_A = 0, PORT_B = 1.
- Sub-module rr_arb2: combinational 2-way round-robin grant from req[1:0] and last_grant; instantiated once.

Test Plan:
- Reset, then a_req read addr 5 (mem[i]=i init) -> a_gnt cycle 1, mem_memread cycle 1, a_rvalid cycle 3, a_rdata = 5; b outputs stay 0.
- b_req write addr 10 data 0xDEADBEEF, then b read addr 10 -> b_wack 2 cycles after sample; read returns 0xDEADBEEF.
- a_req and b_req both asserted continuously, reads of 1 and 2 -> grants A, B, A, B; each rvalid to correct port with 1 resp. 2.
- rst_n pulled low during CAPTURE -> all outputs 0 immediately; no rvalid; next request after reset granted to A on tie.
- ADDR_CHECK_EN defined, a_req read addr 300 -> a_gnt and err same cycle, mem_memread never asserted; undefined -> err stays 0.
